sobel_gradient: RTL and testbench

SOBEL_GRADIENT -- requirements
Module: sobel_gradient

---
 rtl/sobel_gradient.sv | 165 ++++++++++++++++
 tb/tb_sobel_gradient.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_gradient.sv
// sobel_gradient
//   Sobel gradient stage that follows the Gaussian smoother. Raster-order
//   pixels are gathered into a 3x3 window using two line buffers. For every
//   interior centre pixel the block produces a gradient magnitude and a
//   quantized direction.
//
// Handshake: there is no ready signal.
//   - Each cycle with pix_valid_in=1 accepts exactly one pixel. The block
//     never stalls.
//   - grad_valid_out is a single-cycle qualifier for grad_mag_out,
//     grad_dir_out and frame_done.
//   - Output data holds its last value while grad_valid_out=0.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous, active-low reset
//   pix_valid_in     pixel present this cycle
//   sof_in           start of frame (qualified by pix_valid_in)
//   smoothed_data_in 8-bit unsigned pixel
//   grad_valid_out   gradient outputs valid this cycle
//   grad_mag_out     (|Gx|+|Gy|)>>3
//   grad_dir_out     0=0deg 1=45deg 2=90deg 3=135deg
//   frame_done       pulse with the last gradient output of a frame
module sobel_gradient #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid_in,
  input  logic       sof_in,
  input  logic [7:0] smoothed_data_in,
  output logic       grad_valid_out,
  output logic [7:0] grad_mag_out,
  output logic [1:0] grad_dir_out,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  // Position of the next pixel to be accepted
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // Position of the pixel on the input this cycle (sof overrides the counters)
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          last_col;
  logic          last_row;
  logic          discard;

  always_comb begin
    cur_col  = sof_in ? '0 : col;
    cur_row  = sof_in ? '0 : row;
    last_col = (cur_col == CW'(IMG_WIDTH - 1));
    last_row = (cur_row == RW'(IMG_HEIGHT - 1));
    // A new frame start drops everything still in flight from the old frame
    discard  = pix_valid_in & sof_in;
  end

  // line_a holds the previous row, line_b the row before that
  logic [7:0] line_a [IMG_WIDTH];
  logic [7:0] line_b [IMG_WIDTH];
  logic [7:0] win [3][3];  // win[r][c], r=0 top row, c=2 newest column

  always_ff @(posedge clk) begin
    if (pix_valid_in) begin
      line_b[cur_col] <= line_a[cur_col];
      line_a[cur_col] <= smoothed_data_in;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= line_b[cur_col];
      win[1][2] <= line_a[cur_col];
      win[2][2] <= smoothed_data_in;
    end
  end

  // Stage 2: signed gradients. Each sum of weighted pixels is at most 1020,
  // so the 11-bit two's-complement difference is exact.
  logic [10:0]        sum_r, sum_l, sum_b, sum_t;
  logic signed [10:0] gx_c, gy_c;
  logic signed [10:0] gx, gy;
  logic               v1, v2, last1, last2;

  always_comb begin
    sum_r = {3'b0, win[0][2]} + {2'b0, win[1][2], 1'b0} + {3'b0, win[2][2]};
    sum_l = {3'b0, win[0][0]} + {2'b0, win[1][0], 1'b0} + {3'b0, win[2][0]};
    sum_b = {3'b0, win[2][0]} + {2'b0, win[2][1], 1'b0} + {3'b0, win[2][2]};
    sum_t = {3'b0, win[0][0]} + {2'b0, win[0][1], 1'b0} + {3'b0, win[0][2]};
    gx_c  = signed'(sum_r - sum_l);
    gy_c  = signed'(sum_b - sum_t);
  end

  always_ff @(posedge clk) begin
    if (v1) begin
      gx <= gx_c;
      gy <= gy_c;
    end
  end

  // Stage 3: magnitude and direction from the registered gradients
  logic [10:0] ax, ay;
  logic [12:0] ax2, ay2, ax5, ay5;
  logic [7:0]  mag_c;
  logic [1:0]  dir_c;

  always_comb begin
    ax    = gx[10] ? 11'(-gx) : 11'(gx);
    ay    = gy[10] ? 11'(-gy) : 11'(gy);
    mag_c = 8'((ax + ay) >> 3);
    ax2   = {1'b0, ax, 1'b0};
    ay2   = {1'b0, ay, 1'b0};
    ax5   = {2'b0, ax} + {ax, 2'b0};
    ay5   = {2'b0, ay} + {ay, 2'b0};
    dir_c = 2'd0;
    if (ax == '0 && ay == '0) begin
      dir_c = 2'd0;
    end else if (ay5 < ax2) begin
      dir_c = 2'd0;
    end else if (ay2 > ax5) begin
      dir_c = 2'd2;
    end else begin
      // Both gradients are non-zero here, so the sign bits decide
      dir_c = (gx[10] == gy[10]) ? 2'd1 : 2'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col            <= '0;
      row            <= '0;
      v1             <= 1'b0;
      v2             <= 1'b0;
      last1          <= 1'b0;
      last2          <= 1'b0;
      grad_valid_out <= 1'b0;
      grad_mag_out   <= '0;
      grad_dir_out   <= '0;
      frame_done     <= 1'b0;
    end else begin
      if (pix_valid_in) begin
        col   <= last_col ? '0 : cur_col + CW'(1);
        row   <= last_col ? (last_row ? '0 : cur_row + RW'(1)) : cur_row;
        // Window is complete only once two full rows and two columns precede it
        v1    <= (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        last1 <= last_row && last_col;
      end else begin
        v1    <= 1'b0;
        last1 <= 1'b0;
      end
      v2             <= v1 & ~discard;
      last2          <= last1 & ~discard;
      grad_valid_out <= v2 & ~discard;
      frame_done     <= last2 & ~discard;
      if (v2 && !discard) begin
        grad_mag_out <= mag_c;
        grad_dir_out <= dir_c;
      end
    end
  end

endmodule

// File: tb/tb_sobel_gradient.sv
// tb_sobel_gradient
//   Directed bench for sobel_gradient with IMG_WIDTH=5, IMG_HEIGHT=4.
//   - Expected gradient results come from a reference image model.
//   - Each expected result is queued with the edge on which it must appear.
//   - A negedge monitor pops the queue and compares the DUT outputs.
module tb_sobel_gradient;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int EW = 11;  // {frame_done, dir[1:0], mag[7:0]}

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_valid_in = 1'b0;
  logic       sof_in = 1'b0;
  logic [7:0] smoothed_data_in = 8'd0;
  logic       grad_valid_out;
  logic [7:0] grad_mag_out;
  logic [1:0] grad_dir_out;
  logic       frame_done;

  sobel_gradient #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk              (clk),
    .rst              (rst),
    .pix_valid_in     (pix_valid_in),
    .sof_in           (sof_in),
    .smoothed_data_in (smoothed_data_in),
    .grad_valid_out   (grad_valid_out),
    .grad_mag_out     (grad_mag_out),
    .grad_dir_out     (grad_dir_out),
    .frame_done       (frame_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            exp_edge_q[$];
  int            checks = 0;
  int            failures = 0;
  int            img[H][W];
  int            brow = 0;
  int            bcol = 0;
  int            rnd_img[H][W];
  logic [7:0]    last_mag = 8'd0;
  logic [1:0]    last_dir = 2'd0;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: record pixel, and if it completes a window queue the result
  task automatic model_pix(input int d, input bit sof, input int acc_edge);
    int cr, cc, gx, gy, ax, ay, mag, dir;
    logic [EW-1:0] e;
    if (sof) begin
      brow = 0;
      bcol = 0;
      while (exp_edge_q.size() > 0 && exp_edge_q[$] >= acc_edge) begin
        void'(exp_q.pop_back());
        void'(exp_edge_q.pop_back());
      end
    end
    img[brow][bcol] = d;
    if (brow >= 2 && bcol >= 2) begin
      cr = brow - 1;
      cc = bcol - 1;
      gx = (img[cr-1][cc+1] + 2*img[cr][cc+1] + img[cr+1][cc+1])
         - (img[cr-1][cc-1] + 2*img[cr][cc-1] + img[cr+1][cc-1]);
      gy = (img[cr+1][cc-1] + 2*img[cr+1][cc] + img[cr+1][cc+1])
         - (img[cr-1][cc-1] + 2*img[cr-1][cc] + img[cr-1][cc+1]);
      ax  = (gx < 0) ? -gx : gx;
      ay  = (gy < 0) ? -gy : gy;
      mag = (ax + ay) / 8;
      if (ax == 0 && ay == 0)  dir = 0;
      else if (5*ay < 2*ax)    dir = 0;
      else if (2*ay > 5*ax)    dir = 2;
      else                     dir = ((gx > 0) == (gy > 0)) ? 1 : 3;
      e = {(cr == H-2 && cc == W-2) ? 1'b1 : 1'b0, 2'(dir), 8'(mag)};
      exp_q.push_back(e);
      exp_edge_q.push_back(acc_edge + 2);
    end
    if (bcol == W-1) begin
      bcol = 0;
      brow = (brow == H-1) ? 0 : brow + 1;
    end else begin
      bcol++;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic          exp_valid;
    logic [EW-1:0] e;
    if (rst) begin
      exp_valid = (exp_edge_q.size() > 0) && (exp_edge_q[0] == edge_cnt);
      chk("grad_valid", int'(grad_valid_out), int'(exp_valid));
      if (exp_valid) begin
        e = exp_q.pop_front();
        void'(exp_edge_q.pop_front());
        chk("mag", int'(grad_mag_out), int'(e[7:0]));
        chk("dir", int'(grad_dir_out), int'(e[9:8]));
        chk("frame_done", int'(frame_done), int'(e[10]));
        last_mag = e[7:0];
        last_dir = e[9:8];
      end else begin
        chk("hold_mag", int'(grad_mag_out), int'(last_mag));
        chk("hold_dir", int'(grad_dir_out), int'(last_dir));
        chk("frame_done_idle", int'(frame_done), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; the pixel is accepted on the next edge
  task automatic pix(input bit v, input bit s, input int d);
    pix_valid_in     = v;
    sof_in           = s;
    smoothed_data_in = 8'(d);
    @(posedge clk);
    #1;
    if (v) model_pix(d, s, edge_cnt);
    pix_valid_in = 1'b0;
    sof_in       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) pix(1'b0, 1'b0, 0);
  endtask

  task automatic do_reset(input int cycles);
    rst          = 1'b0;
    pix_valid_in = 1'b0;
    sof_in       = 1'b0;
    exp_q.delete();
    exp_edge_q.delete();
    brow     = 0;
    bcol     = 0;
    last_mag = 8'd0;
    last_dir = 2'd0;
    #1;
    chk("rst_valid", int'(grad_valid_out), 0);
    chk("rst_mag", int'(grad_mag_out), 0);
    chk("rst_dir", int'(grad_dir_out), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic int pixel_of(input int kind, input int r, input int c);
    case (kind)
      0:       return 100;
      1:       return (c >= 3) ? 255 : 0;
      2:       return (c >= 3) ? 0 : 255;
      3:       return (r >= 2) ? 200 : 0;
      4:       return (c > r) ? 255 : 0;
      default: return rnd_img[r][c];
    endcase
  endfunction

  // gaps=1 inserts random idle cycles before each pixel
  task automatic send_frame(input int kind, input bit use_sof, input bit gaps);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gaps) begin
          while ($urandom_range(0, 1) == 1) pix(1'b0, 1'b0, 0);
        end
        pix(1'b1, use_sof && r == 0 && c == 0, pixel_of(kind, r, c));
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        rnd_img[r][c] = $urandom_range(0, 255);

    @(posedge clk);
    #1;
    do_reset(3);

    send_frame(0, 1'b1, 1'b0);  // flat
    idle(4);
    send_frame(1, 1'b1, 1'b0);  // vertical edge
    send_frame(2, 1'b1, 1'b0);  // vertical edge, sides swapped
    send_frame(3, 1'b1, 1'b0);  // horizontal edge
    send_frame(4, 1'b1, 1'b0);  // diagonal step
    idle(3);
    send_frame(5, 1'b1, 1'b0);  // random image, continuous
    idle(3);
    send_frame(5, 1'b1, 1'b1);  // same image with gaps
    idle(4);

    // Reset after 7 pixels, then a full frame without sof
    for (int i = 0; i < 7; i++) pix(1'b1, i == 0, pixel_of(5, i / W, i % W));
    do_reset(2);
    send_frame(5, 1'b0, 1'b0);
    idle(4);

    // Frame restarted by sof after 9 pixels
    for (int i = 0; i < 9; i++) pix(1'b1, i == 0, pixel_of(3, i / W, i % W));
    send_frame(5, 1'b1, 1'b0);
    idle(5);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
